// File: rtl/digit_result_filter.sv
// Per-frame temporal filter for digit-recognition channels.
// Publishes a digit after stable frames and blanks after a long non-digit run.
module digit_result_filter #(
    parameter int          NUM_CH        = 4,
    parameter int          STABLE_FRAMES = 3,
    parameter int          BLANK_FRAMES  = 8,
    parameter logic [3:0]  BLANK_CODE    = 4'hF,
    parameter logic        VS_ACTIVE     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  freeze,
    input  logic [4*NUM_CH-1:0]   fig_in,
    output logic [4*NUM_CH-1:0]   fig_out,
    output logic [NUM_CH-1:0]     fig_valid,
    output logic                  update
);

    localparam logic [3:0] LP_STABLE = 4'(STABLE_FRAMES);
    localparam logic [7:0] LP_BLANK  = 8'(BLANK_FRAMES);

    logic                r_vs_d;
    logic                r_update;
    logic [4*NUM_CH-1:0] r_out;
    logic [NUM_CH-1:0]   r_valid;
    logic [3:0]          r_cand [NUM_CH];
    logic [3:0]          r_cnt  [NUM_CH];
    logic [7:0]          r_miss [NUM_CH];

    logic                w_tick;
    logic [3:0]          w_x     [NUM_CH];
    logic [3:0]          w_cnt_n [NUM_CH];
    logic [7:0]          w_miss_n[NUM_CH];
    logic [NUM_CH-1:0]   w_dig;
    logic [NUM_CH-1:0]   w_commit;
    logic [NUM_CH-1:0]   w_blank;

    // Frame start: entry into the active vsync level, suppressed while frozen
    assign w_tick = (vsync == VS_ACTIVE) && (r_vs_d != VS_ACTIVE) && !freeze;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_x[i]   = fig_in[4*i +: 4];
            w_dig[i] = (w_x[i] <= 4'd9);
            if (w_x[i] == r_cand[i]) begin
                w_cnt_n[i] = (r_cnt[i] == LP_STABLE) ? r_cnt[i] : r_cnt[i] + 4'd1;
            end else begin
                w_cnt_n[i] = 4'd1;
            end
            if (w_dig[i]) begin
                w_miss_n[i] = 8'd0;
            end else begin
                w_miss_n[i] = (r_miss[i] == LP_BLANK) ? r_miss[i] : r_miss[i] + 8'd1;
            end
            w_commit[i] = w_dig[i] && (w_cnt_n[i] == LP_STABLE)
                          && (!r_valid[i] || (r_out[4*i +: 4] != w_x[i]));
            w_blank[i]  = !w_dig[i] && (w_miss_n[i] == LP_BLANK) && r_valid[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_vs_d   <= VS_ACTIVE;
            r_update <= 1'b0;
            r_out    <= {NUM_CH{BLANK_CODE}};
            r_valid  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_cand[i] <= 4'd0;
                r_cnt[i]  <= 4'd0;
                r_miss[i] <= 8'd0;
            end
        end else begin
            r_vs_d   <= vsync;
            r_update <= w_tick && |(w_commit | w_blank);
            if (w_tick) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r_cand[i] <= w_x[i];
                    r_cnt[i]  <= w_cnt_n[i];
                    r_miss[i] <= w_miss_n[i];
                    if (w_commit[i]) begin
                        r_out[4*i +: 4] <= w_x[i];
                        r_valid[i]      <= 1'b1;
                    end else if (w_blank[i]) begin
                        r_out[4*i +: 4] <= BLANK_CODE;
                        r_valid[i]      <= 1'b0;
                    end
                end
            end
        end
    end

    assign fig_out   = r_out;
    assign fig_valid = r_valid;
    assign update    = r_update;

endmodule

// File: tb/tb_digit_result_filter.sv
// Directed scoreboard bench for digit_result_filter at default parameters.
// Expected outputs are queued per frame and compared after the tick edge.
module tb_digit_result_filter;

    logic        clk;
    logic        reset;
    logic        vsync;
    logic        freeze;
    logic [15:0] fig_in;
    logic [15:0] fig_out;
    logic [3:0]  fig_valid;
    logic        update;

    int checks = 0;
    int errors = 0;
    int frame_no = 0;

    logic [20:0] exp_q [$];

    digit_result_filter dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .freeze    (freeze),
        .fig_in    (fig_in),
        .fig_out   (fig_out),
        .fig_valid (fig_valid),
        .update    (update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [20:0] obs,
                         input logic [20:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [15:0] eo,
                               input logic [3:0] ev, input logic eu);
        check(tag, {fig_out, fig_valid, update}, {eo, ev, eu});
    endtask

    // One frame: push expectation, pulse vsync high for one cycle, compare
    task automatic frame(input logic [15:0] fin, input logic [15:0] eo,
                         input logic [3:0] ev, input logic eu);
        logic [20:0] e;
        frame_no++;
        exp_q.push_back({eo, ev, eu});
        @(negedge clk);
        fig_in = fin;
        vsync  = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        fig_in = 16'h0000;
        e = exp_q.pop_front();
        check($sformatf("frame%0d", frame_no), {fig_out, fig_valid, update}, e);
        @(negedge clk);
        check($sformatf("frame%0d_after", frame_no),
              {fig_out, fig_valid, update}, {e[20:1], 1'b0});
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b0;
        vsync  = 1'b0;
        freeze = 1'b0;
        fig_in = 16'h0000;
        repeat (2) @(negedge clk);
        check_state("reset", 16'hFFFF, 4'b0000, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_state("post_reset", 16'hFFFF, 4'b0000, 1'b0);

        // ch0 commits 7 on the third frame
        frame(16'hFFF7, 16'hFFFF, 4'b0000, 1'b0);
        frame(16'hFFF7, 16'hFFFF, 4'b0000, 1'b0);
        frame(16'hFFF7, 16'hFFF7, 4'b0001, 1'b1);

        // ch1 glitch 5,5,2,5,5,5
        frame(16'hFF57, 16'hFFF7, 4'b0001, 1'b0);
        frame(16'hFF57, 16'hFFF7, 4'b0001, 1'b0);
        frame(16'hFF27, 16'hFFF7, 4'b0001, 1'b0);
        frame(16'hFF57, 16'hFFF7, 4'b0001, 1'b0);
        frame(16'hFF57, 16'hFFF7, 4'b0001, 1'b0);
        frame(16'hFF57, 16'hFF57, 4'b0011, 1'b1);

        // ch2 commits 4, then 8 non-digit frames blank it
        frame(16'hF457, 16'hFF57, 4'b0011, 1'b0);
        frame(16'hF457, 16'hFF57, 4'b0011, 1'b0);
        frame(16'hF457, 16'hF457, 4'b0111, 1'b1);
        for (int k = 0; k < 7; k++)
            frame(16'hFA57, 16'hF457, 4'b0111, 1'b0);
        frame(16'hFA57, 16'hFF57, 4'b0011, 1'b1);

        // frozen frames of 9 on ch3 are lost
        freeze = 1'b1;
        for (int k = 0; k < 5; k++)
            frame(16'h9F57, 16'hFF57, 4'b0011, 1'b0);
        freeze = 1'b0;
        frame(16'h9F57, 16'hFF57, 4'b0011, 1'b0);
        frame(16'h9F57, 16'hFF57, 4'b0011, 1'b0);
        frame(16'h9F57, 16'h9F57, 4'b1011, 1'b1);

        // ch0 at cnt=2 for new digit 3, then reset mid-frame
        frame(16'h9F53, 16'h9F57, 4'b1011, 1'b0);
        frame(16'h9F53, 16'h9F57, 4'b1011, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check_state("mid_reset", 16'hFFFF, 4'b0000, 1'b0);
        @(negedge clk);
        frame(16'h9F53, 16'hFFFF, 4'b0000, 1'b0);
        frame(16'h9F53, 16'hFFFF, 4'b0000, 1'b0);
        frame(16'h9F53, 16'h9F53, 4'b1011, 1'b1);

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
